// File: rtl/light_conflict_monitor.sv
// Passive safety monitor for the intersection light outputs: checks legal pairs, phase order
// and dwell limits, and latches the first fault with a code while driving a flash output.
module light_conflict_monitor #(
  parameter int unsigned MIN_GREEN = 3,
  parameter int unsigned MIN_YEL   = 2,
  parameter int unsigned MAX_DWELL = 40
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic [1:0] main_light_i,
  input  logic [1:0] side_light_i,
  input  logic       walk_light_i,
  input  logic       clear_fault_i,
  output logic       fault_o,
  output logic [2:0] fault_code_o,
  output logic       flash_o,
  output logic [7:0] dwell_cnt_o,
  output logic [7:0] cycle_count_o
);

  typedef logic [3:0] pair_t;

  localparam logic [1:0] L_OFF = 2'd0;
  localparam logic [1:0] L_GRN = 2'd1;
  localparam logic [1:0] L_YEL = 2'd2;
  localparam logic [1:0] L_RED = 2'd3;

  localparam pair_t P_OFF = {L_OFF, L_OFF};
  localparam pair_t P_GR  = {L_GRN, L_RED};
  localparam pair_t P_YR  = {L_YEL, L_RED};
  localparam pair_t P_RG  = {L_RED, L_GRN};
  localparam pair_t P_RY  = {L_RED, L_YEL};
  localparam pair_t P_RR  = {L_RED, L_RED};

  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_CONFLICT = 3'd1;
  localparam logic [2:0] C_WALK     = 3'd2;
  localparam logic [2:0] C_ORDER    = 3'd3;
  localparam logic [2:0] C_SHORT_Y  = 3'd4;
  localparam logic [2:0] C_SHORT_G  = 3'd5;
  localparam logic [2:0] C_STUCK    = 3'd6;

  localparam logic [7:0] MIN_GREEN_C = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_YEL_C   = 8'(MIN_YEL);
  localparam logic [7:0] MAX_DWELL_C = 8'(MAX_DWELL);
  localparam logic [7:0] DWELL_SAT   = 8'd255;

  // A pair the controller may legitimately drive once it is running.
  function automatic logic is_run_pair(input pair_t p);
    logic ok;
    case (p)
      P_GR, P_YR, P_RG, P_RY, P_RR: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Legal phase advance between two different running pairs.
  function automatic logic is_legal_step(input pair_t from_p, input pair_t to_p);
    logic ok;
    case (from_p)
      P_GR:    ok = (to_p == P_YR);
      P_YR:    ok = (to_p == P_RG) || (to_p == P_RR);
      P_RR:    ok = (to_p == P_RG);
      P_RG:    ok = (to_p == P_RY);
      P_RY:    ok = (to_p == P_GR);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  pair_t      prev_q, prev_d;
  logic [7:0] dwell_q, dwell_d;
  logic       startup_q, startup_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;
  logic       flash_q, flash_d;
  logic [7:0] cycle_q, cycle_d;

  pair_t      cur_s;
  pair_t      eff_prev_s;
  logic       rearm_s;
  logic       eff_startup_s;
  logic       changed_s;
  logic       pair_ok_s;
  logic       step_ok_s;
  logic       exit_yel_s;
  logic       exit_grn_s;
  logic       stuck_s;
  logic [2:0] viol_code_s;
  logic       viol_s;

  // A clear on a faulted tick re-arms: this tick is judged as if just out of reset.
  always_comb begin
    cur_s         = {main_light_i, side_light_i};
    rearm_s       = fault_q & clear_fault_i;
    eff_prev_s    = rearm_s ? P_OFF : prev_q;
    eff_startup_s = rearm_s | startup_q;
    changed_s     = (cur_s != eff_prev_s);

    if (changed_s) begin
      dwell_d = 8'd1;
    end else if (dwell_q == DWELL_SAT) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + 8'd1;
    end

    pair_ok_s  = is_run_pair(cur_s) | (eff_startup_s & (cur_s == P_OFF));
    step_ok_s  = ~changed_s | (eff_startup_s & (eff_prev_s == P_OFF))
               | is_legal_step(eff_prev_s, cur_s);
    exit_yel_s = changed_s & ((eff_prev_s == P_YR) | (eff_prev_s == P_RY))
               & (dwell_q < MIN_YEL_C);
    exit_grn_s = changed_s & ((eff_prev_s == P_GR) | (eff_prev_s == P_RG))
               & (dwell_q < MIN_GREEN_C);
    stuck_s    = ~changed_s & (cur_s != P_OFF) & (dwell_d >= MAX_DWELL_C);
  end

  // Lowest-numbered violation wins when several fire together.
  always_comb begin
    if (!pair_ok_s) begin
      viol_code_s = C_CONFLICT;
    end else if (walk_light_i && (cur_s != P_RR)) begin
      viol_code_s = C_WALK;
    end else if (!step_ok_s) begin
      viol_code_s = C_ORDER;
    end else if (exit_yel_s) begin
      viol_code_s = C_SHORT_Y;
    end else if (exit_grn_s) begin
      viol_code_s = C_SHORT_G;
    end else if (stuck_s) begin
      viol_code_s = C_STUCK;
    end else begin
      viol_code_s = C_NONE;
    end
    viol_s = (viol_code_s != C_NONE);
  end

  // Fault latch, flasher, cycle counter and tracking state next values.
  always_comb begin
    prev_d    = cur_s;
    startup_d = eff_startup_s & ~is_run_pair(cur_s);

    if (fault_q && !clear_fault_i) begin
      fault_d = 1'b1;
      code_d  = code_q;
      flash_d = ~flash_q;
    end else if (viol_s) begin
      fault_d = 1'b1;
      code_d  = viol_code_s;
      flash_d = 1'b1;
    end else begin
      fault_d = 1'b0;
      code_d  = C_NONE;
      flash_d = 1'b0;
    end

    if (!fault_q && !viol_s && (eff_prev_s == P_RY) && (cur_s == P_GR)) begin
      cycle_d = cycle_q + 8'd1;
    end else begin
      cycle_d = cycle_q;
    end
  end

  // State registers; synchronous reset overrides every other input.
  always_ff @(posedge clk_out) begin
    if (reset) begin
      prev_q    <= P_OFF;
      dwell_q   <= 8'd0;
      startup_q <= 1'b1;
      fault_q   <= 1'b0;
      code_q    <= C_NONE;
      flash_q   <= 1'b0;
      cycle_q   <= 8'd0;
    end else begin
      prev_q    <= prev_d;
      dwell_q   <= dwell_d;
      startup_q <= startup_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      flash_q   <= flash_d;
      cycle_q   <= cycle_d;
    end
  end

  assign fault_o       = fault_q;
  assign fault_code_o  = code_q;
  assign flash_o       = flash_q;
  assign dwell_cnt_o   = dwell_q;
  assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench for light_conflict_monitor: a vector table for single-tick cases plus
// hand-written sequences for the full cycle, stuck timeout and dwell saturation.
module tb_light_conflict_monitor;

  localparam logic [1:0] O = 2'd0;
  localparam logic [1:0] G = 2'd1;
  localparam logic [1:0] Y = 2'd2;
  localparam logic [1:0] R = 2'd3;

  logic       clk_out = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] main_light = 2'd0;
  logic [1:0] side_light = 2'd0;
  logic       walk_light = 1'b0;
  logic       clear_fault = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [7:0] dwell_cnt;
  logic [7:0] cycle_count;

  int total = 0;
  int bad = 0;

  light_conflict_monitor dut (
    .clk_out      (clk_out),
    .reset        (reset),
    .main_light_i (main_light),
    .side_light_i (side_light),
    .walk_light_i (walk_light),
    .clear_fault_i(clear_fault),
    .fault_o      (fault),
    .fault_code_o (fault_code),
    .flash_o      (flash),
    .dwell_cnt_o  (dwell_cnt),
    .cycle_count_o(cycle_count)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    logic       rst;
    logic [1:0] m;
    logic [1:0] s;
    logic       w;
    logic       clr;
    logic       ef;
    logic [2:0] ec;
    logic       efl;
    logic [7:0] ed;
    logic [7:0] ecc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic [1:0] m, input logic [1:0] s,
                      input logic w, input logic clr);
    @(negedge clk_out);
    reset = rst;
    main_light = m;
    side_light = s;
    walk_light = w;
    clear_fault = clr;
    @(posedge clk_out);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ef, input logic [2:0] ec,
                           input logic efl, input logic [7:0] ed, input logic [7:0] ecc);
    check({tag, ".fault"}, int'(fault), int'(ef));
    check({tag, ".code"}, int'(fault_code), int'(ec));
    check({tag, ".flash"}, int'(flash), int'(efl));
    check({tag, ".dwell"}, int'(dwell_cnt), int'(ed));
    check({tag, ".cycles"}, int'(cycle_count), int'(ecc));
  endtask

  initial begin
    // rst  m  s  w     clr   | fault code  flash dwell  cycles
    vecs[0]  = '{1'b0, G, G, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 8'd1, 8'd3};
    vecs[1]  = '{1'b0, Y, R, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'd1, 8'd3};
    vecs[2]  = '{1'b0, G, R, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 8'd1, 8'd3};
    vecs[3]  = '{1'b0, G, R, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd1, 8'd3};
    vecs[4]  = '{1'b0, G, R, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd2, 8'd3};
    vecs[5]  = '{1'b0, G, R, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd3, 8'd3};
    vecs[6]  = '{1'b0, Y, R, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1, 8'd3};
    vecs[7]  = '{1'b0, R, G, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'd1, 8'd3};
    vecs[8]  = '{1'b0, R, G, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd1, 8'd3};
    vecs[9]  = '{1'b0, R, G, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd2, 8'd3};
    vecs[10] = '{1'b0, R, Y, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 8'd1, 8'd3};
    vecs[11] = '{1'b0, R, G, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd1, 8'd3};
    vecs[12] = '{1'b0, R, G, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 8'd2, 8'd3};
    vecs[13] = '{1'b0, R, G, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd1, 8'd3};
    vecs[14] = '{1'b0, G, G, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 8'd1, 8'd3};
    vecs[15] = '{1'b1, G, G, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0, 8'd0};
    vecs[16] = '{1'b0, R, Y, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1, 8'd0};
    vecs[17] = '{1'b0, R, Y, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd2, 8'd0};
    vecs[18] = '{1'b0, R, G, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'd1, 8'd0};
    vecs[19] = '{1'b0, R, G, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'd2, 8'd0};

    tick(1'b1, O, O, 1'b0, 1'b0);
    tick(1'b1, O, O, 1'b0, 1'b0);
    check_all("reset", 1'b0, 3'd0, 1'b0, 8'd0, 8'd0);

    // Three full cycles G=6, Y=2, g=6, y=2 starting from (off,off).
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 4; p++) begin
        int len;
        logic [1:0] pm;
        logic [1:0] ps;
        len = (p == 0 || p == 2) ? 6 : 2;
        pm = (p == 0) ? G : (p == 1) ? Y : R;
        ps = (p == 2) ? G : (p == 3) ? Y : R;
        for (int k = 0; k < len; k++) begin
          tick(1'b0, pm, ps, 1'b0, 1'b0);
          check("cycle.fault", int'(fault), 0);
          check("cycle.dwell", int'(dwell_cnt), k + 1);
          check("cycle.count", int'(cycle_count), c);
        end
      end
    end
    tick(1'b0, G, R, 1'b0, 1'b0);
    check_all("cycle.end", 1'b0, 3'd0, 1'b0, 8'd1, 8'd3);

    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].rst, vecs[i].m, vecs[i].s, vecs[i].w, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ec, vecs[i].efl,
                vecs[i].ed, vecs[i].ecc);
    end

    // Stuck (G,r): no fault through tick 39, stuck fault on tick 40.
    tick(1'b1, O, O, 1'b0, 1'b0);
    for (int k = 1; k <= 39; k++) begin
      tick(1'b0, G, R, 1'b0, 1'b0);
    end
    check_all("stuck.t39", 1'b0, 3'd0, 1'b0, 8'd39, 8'd0);
    tick(1'b0, G, R, 1'b0, 1'b0);
    check_all("stuck.t40", 1'b1, 3'd6, 1'b1, 8'd40, 8'd0);
    tick(1'b0, G, R, 1'b0, 1'b1);
    check_all("stuck.clear", 1'b0, 3'd0, 1'b0, 8'd1, 8'd0);
    tick(1'b0, G, R, 1'b0, 1'b0);
    check_all("stuck.after", 1'b0, 3'd0, 1'b0, 8'd2, 8'd0);

    // Keep holding well past 255 ticks: dwell saturates, first code stays latched.
    for (int k = 0; k < 300; k++) begin
      tick(1'b0, G, R, 1'b0, 1'b0);
    end
    check("sat.dwell", int'(dwell_cnt), 255);
    check("sat.code", int'(fault_code), 6);
    check("sat.fault", int'(fault), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
